conv2x2_window_gen: RTL and testbench
=====================================

// Module: conv2x2_window_gen
// PURPOSE
//  Upstream feeder for the 2x2 convolution stage. Accepts a raster-order pixel stream
//  (row-major, one DATA_W pixel per beat) and emits every 2x2 window {tl,tr,bl,br}.
//  Holds one line plus one pixel of history. Sits between the byte-serial input port
//  and the MAC/convolution stage, which consumes one packed window per handshake.
// PARAMETERS
//  DATA_W  8   pixel width, bits
//  IMG_W   16  pixels per row, >=2; row length is fixed
//  IMG_H   16  rows per frame, >=2
// PORTS
//  clk        in   1         single clock; all logic on posedge
//  rst        in   1         synchronous reset, active-high
//  pix_data   in   DATA_W    input pixel
//  pix_sof    in   1         start of frame; sampled only on an accepted beat
//  pix_valid  in   1         input beat valid
//  pix_ready  out  1         input beat accepted when pix_valid & pix_ready
//  win_data   out  4*DATA_W  {br,bl,tr,tl}; tl in [DATA_W-1:0]
//  win_eol    out  1         window is the last window of its row
//  win_eof    out  1         window is the last window of the frame
//  win_valid  out  1         output window valid
//  win_ready  in   1         downstream accepts when win_valid & win_ready
// BEHAVIOUR
//  Interface: one clock, clk. Reset rst is synchronous and active-high.
//  Reset: win_valid=0, win_data=0, win_eol=0, win_eof=0, col=0, row=0.
//   History contents are don't-care. pix_ready is combinational.
//  Handshake: pix_ready = !win_valid | win_ready (one-deep output register, no bubble).
//   win_data, win_eol and win_eof are stable while win_valid & !win_ready.
//   win_valid is never dropped before it is accepted.
//  History: shift register hist[0..IMG_W], shifted only on an accepted input beat;
//   hist[0] <= pix_data.
//  Position: col/row counters count accepted beats.
//   col wraps at IMG_W-1 -> 0 and increments row. row wraps at IMG_H-1 -> 0.
//   If pix_sof=1 on an accepted beat, that beat is (row 0, col 0): counters are forced
//   to 0 before use, so a mid-frame SOF restarts the frame.
//  Window emit: for an accepted beat at (row>=1, col>=1), on the next edge
//   win_valid<=1 and win_data<={pix_data, hist[0], hist[IMG_W-1], hist[IMG_W]}
//   (br = current, bl = previous pixel, tr = IMG_W back, tl = IMG_W+1 back).
//   win_eol = (col==IMG_W-1); win_eof = win_eol & (row==IMG_H-1).
//   Beats in row 0 or col 0 produce no window.
//  Latency: 1 cycle from accepted completing pixel to win_valid.
//  Simultaneous: win accept and new emitting beat in the same cycle -> win_valid stays 1
//   and the new window loads; accept with a non-emitting beat -> win_valid<=0.
//  Count: (IMG_W-1)*(IMG_H-1) windows per frame; exactly one with win_eof=1.
//  Reset mid-operation: pending window is discarded; the next beat is (0,0) regardless
//   of pix_sof.
//  Arithmetic: counters are $clog2 of IMG_W and IMG_H; no pixel arithmetic in this block.
// STRUCTURE
//  conv_pkg: DATA_W default, window field offsets (TL/TR/BL/BR lsb), window width.
//  Sub-module conv_line_buffer: parameterised shift register (depth IMG_W+1, shift-enable),
//   exposing taps 0, IMG_W-1 and IMG_W.
//  Top level holds counters, emit decision and the output register.
// TESTING (IMG_W=4, IMG_H=3, pixels 0..11 with pix_sof on pixel 0)
//  Stream 0..11, win_ready=1 -> 6 windows. First {tl,tr,bl,br}={0,1,4,5}.
//   Last {6,7,10,11} with win_eol=1 and win_eof=1.
//  Same stream with win_ready low for 3 cycles at the first window -> pix_ready=0 and
//   win_data is held at {0,1,4,5}. No window is lost or duplicated; the sequence is unchanged.
//  pix_valid toggled 1/0 each cycle -> the window sequence is identical; no spurious
//   win_valid pulses.
//  pix_sof reasserted on pixel 6 mid-frame -> the next window comes only after row 1 col 1
//   of the new frame: tl = restarted pixel 0.
//  rst pulsed while win_valid=1 -> next cycle win_valid=0 and all outputs are 0.
//   A fresh 0..11 stream gives the same 6 windows.
//  Two back-to-back frames -> 12 windows and two win_eof pulses. The second frame's first
//   window uses only second-frame pixels.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants for the 2x2 convolution front end:
// default pixel width and packed window field layout.
package conv_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int WIN_N      = 4;
    localparam int DEF_WIN_W  = WIN_N * DEF_DATA_W;

    typedef enum logic [1:0] {
        WIN_TL = 2'd0,
        WIN_TR = 2'd1,
        WIN_BL = 2'd2,
        WIN_BR = 2'd3
    } win_pos_e;

    localparam int TL_LSB = int'(WIN_TL) * DEF_DATA_W;
    localparam int TR_LSB = int'(WIN_TR) * DEF_DATA_W;
    localparam int BL_LSB = int'(WIN_BL) * DEF_DATA_W;
    localparam int BR_LSB = int'(WIN_BR) * DEF_DATA_W;

    function automatic int win_lsb(
        input win_pos_e pos,
        input int       dw
    );
        return int'(pos) * dw;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Pixel history shift register with taps at the previous pixel,
// one row back and one row plus one pixel back.
module conv_line_buffer
    import conv_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 17
) (
    input  logic              clk,
    input  logic              shift_en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] tap_0,
    output logic [DATA_W-1:0] tap_n1,
    output logic [DATA_W-1:0] tap_n
);

    logic [DATA_W-1:0] hist [DEPTH];

    always_ff @(posedge clk) begin
        if (shift_en) begin
            hist[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                hist[i] <= hist[i-1];
            end
        end
    end

    assign tap_0  = hist[0];
    assign tap_n1 = hist[DEPTH-2];
    assign tap_n  = hist[DEPTH-1];

endmodule

// File: rtl/conv2x2_window_gen.sv
// Raster pixel stream to 2x2 window stream with a one-deep
// output register; one window per pixel at row>=1, col>=1.
module conv2x2_window_gen
    import conv_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_W-1:0]         pix_data,
    input  logic                      pix_sof,
    input  logic                      pix_valid,
    output logic                      pix_ready,
    output logic [WIN_N*DATA_W-1:0]   win_data,
    output logic                      win_eol,
    output logic                      win_eof,
    output logic                      win_valid,
    input  logic                      win_ready
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    localparam int TL = win_lsb(WIN_TL, DATA_W);
    localparam int TR = win_lsb(WIN_TR, DATA_W);
    localparam int BL = win_lsb(WIN_BL, DATA_W);
    localparam int BR = win_lsb(WIN_BR, DATA_W);

    logic [CW-1:0] col;
    logic [CW-1:0] col_cur;
    logic [CW-1:0] col_nxt;
    logic [RW-1:0] row;
    logic [RW-1:0] row_cur;
    logic [RW-1:0] row_nxt;

    logic accept;
    logic emit;
    logic at_eol;
    logic at_eof;

    logic [DATA_W-1:0] tap_prev;
    logic [DATA_W-1:0] tap_up;
    logic [DATA_W-1:0] tap_diag;

    logic [WIN_N*DATA_W-1:0] win_nxt;

    assign pix_ready = !win_valid || win_ready;
    assign accept    = pix_valid && pix_ready;

    conv_line_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W + 1)
    ) u_line_buf (
        .clk      (clk),
        .shift_en (accept),
        .din      (pix_data),
        .tap_0    (tap_prev),
        .tap_n1   (tap_up),
        .tap_n    (tap_diag)
    );

    // SOF forces the current beat to (0,0) before any decision uses it
    always_comb begin
        col_cur = col;
        row_cur = row;
        col_nxt = col;
        row_nxt = row;
        at_eol  = 1'b0;
        at_eof  = 1'b0;
        emit    = 1'b0;
        win_nxt = '0;

        if (pix_sof) begin
            col_cur = '0;
            row_cur = '0;
        end

        at_eol = (col_cur == COL_LAST);
        at_eof = at_eol && (row_cur == ROW_LAST);
        emit   = accept && (col_cur != '0) && (row_cur != '0);

        if (at_eol) begin
            col_nxt = '0;
            if (row_cur == ROW_LAST) begin
                row_nxt = '0;
            end else begin
                row_nxt = row_cur + 1'b1;
            end
        end else begin
            col_nxt = col_cur + 1'b1;
            row_nxt = row_cur;
        end

        win_nxt[TL +: DATA_W] = tap_diag;
        win_nxt[TR +: DATA_W] = tap_up;
        win_nxt[BL +: DATA_W] = tap_prev;
        win_nxt[BR +: DATA_W] = pix_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            col <= col_nxt;
            row <= row_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_valid <= 1'b0;
            win_data  <= '0;
            win_eol   <= 1'b0;
            win_eof   <= 1'b0;
        end else if (emit) begin
            win_valid <= 1'b1;
            win_data  <= win_nxt;
            win_eol   <= at_eol;
            win_eof   <= at_eof;
        end else if (win_ready) begin
            win_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv2x2_window_gen.sv
// Randomised bench for conv2x2_window_gen against a frame-array
// reference model of the 2x2 window stream.
module tb_conv2x2_window_gen;

    localparam int DW = 8;
    localparam int IW = 4;
    localparam int IH = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] pix_data = '0;
    logic          pix_sof = 1'b0;
    logic          pix_valid = 1'b0;
    logic          pix_ready;
    logic [4*DW-1:0] win_data;
    logic          win_eol;
    logic          win_eof;
    logic          win_valid;
    logic          win_ready = 1'b1;

    always #5 clk = ~clk;

    conv2x2_window_gen #(
        .DATA_W (DW),
        .IMG_W  (IW),
        .IMG_H  (IH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pix_data  (pix_data),
        .pix_sof   (pix_sof),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .win_data  (win_data),
        .win_eol   (win_eol),
        .win_eof   (win_eof),
        .win_valid (win_valid),
        .win_ready (win_ready)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(
        input string       tag,
        input logic [63:0] got,
        input logic [63:0] exp
    );
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference model: the frame as a 2D array, windows looked up by position
    logic [DW-1:0] img [IH][IW];
    logic [33:0]   exp_q [$];
    int            mr = 0;
    int            mc = 0;
    bit            m_vld = 1'b0;
    bit            m_hold = 1'b0;
    logic [33:0]   held = '0;

    int          n_win = 0;
    int          n_eof = 0;
    logic [31:0] first_w = '0;
    logic [31:0] last_w = '0;
    bit          last_eol = 1'b0;
    bit          last_eof = 1'b0;

    always @(negedge clk) begin
        logic [33:0] got;
        logic [33:0] e;
        bit          emit;
        if (rst) begin
            exp_q.delete();
            mr = 0;
            mc = 0;
            m_vld = 1'b0;
            m_hold = 1'b0;
        end else begin
            got = {win_eof, win_eol, win_data};
            check("win_valid", 64'(win_valid), 64'(m_vld));
            check("pix_ready", 64'(pix_ready), 64'(!m_vld || win_ready));
            if (m_hold && win_valid) check("win_hold", 64'(got), 64'(held));
            if (win_valid && win_ready) begin
                check("win_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("win_word", 64'(got), 64'(e));
                end
                if (n_win == 0) first_w = got[31:0];
                last_w = got[31:0];
                last_eol = got[32];
                last_eof = got[33];
                if (got[33]) n_eof++;
                n_win++;
            end
            m_hold = win_valid && !win_ready;
            held = got;
            emit = 1'b0;
            if (pix_valid && (!m_vld || win_ready)) begin
                if (pix_sof) begin
                    mr = 0;
                    mc = 0;
                end
                img[mr][mc] = pix_data;
                if (mr > 0 && mc > 0) begin
                    e = {(mc == IW-1) && (mr == IH-1), (mc == IW-1),
                         pix_data, img[mr][mc-1],
                         img[mr-1][mc], img[mr-1][mc-1]};
                    exp_q.push_back(e);
                    emit = 1'b1;
                end
                if (mc == IW-1) begin
                    mc = 0;
                    mr = (mr == IH-1) ? 0 : mr + 1;
                end else begin
                    mc++;
                end
            end
            m_vld = emit || (m_vld && !win_ready);
        end
    end

    // 0: always ready, 1: random, 2: stall at next window, 3: never
    int ready_mode = 0;
    int stall_left = 0;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: win_ready = 1'b1;
            1: win_ready = 1'($urandom_range(0, 1));
            2: begin
                if (win_valid && stall_left > 0) begin
                    win_ready = 1'b0;
                    stall_left--;
                end else begin
                    win_ready = 1'b1;
                end
            end
            default: win_ready = 1'b0;
        endcase
    end

    // 0: no gaps, 1: one idle cycle per beat, 2: random gaps
    int gap_mode = 0;

    task automatic send_pix(input logic [DW-1:0] d, input bit sof);
        int gap;
        int t;
        bit acc;
        gap = (gap_mode == 1) ? 1 : (gap_mode == 2) ? $urandom_range(0, 2) : 0;
        repeat (gap) begin
            pix_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        pix_data = d;
        pix_sof = sof;
        pix_valid = 1'b1;
        t = 0;
        acc = 1'b0;
        do begin
            @(negedge clk);
            acc = pix_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!acc && t < 200);
        check("beat_accept", 64'(acc), 64'd1);
        pix_valid = 1'b0;
        pix_sof = 1'b0;
    endtask

    task automatic send_frame(input logic [DW-1:0] base, input int n, input bit sof);
        for (int i = 0; i < n; i++) send_pix(base + DW'(i), sof && (i == 0));
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || win_valid) && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_q", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic clear_stats();
        n_win = 0;
        n_eof = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(win_valid), 64'd0);
        check("rst_data", 64'(win_data), 64'd0);
        check("rst_eol", 64'(win_eol), 64'd0);
        check("rst_eof", 64'(win_eof), 64'd0);
        rst = 1'b0;

        clear_stats();
        send_frame(8'h00, 12, 1'b1);
        drain();
        check("t1_count", 64'(n_win), 64'd6);
        check("t1_eofs", 64'(n_eof), 64'd1);
        check("t1_first", 64'(first_w), 64'h05040100);
        check("t1_last", 64'(last_w), 64'h0B0A0706);
        check("t1_last_eol", 64'(last_eol), 64'd1);
        check("t1_last_eof", 64'(last_eof), 64'd1);

        stall_left = 3;
        ready_mode = 2;
        clear_stats();
        send_frame(8'h00, 12, 1'b1);
        drain();
        check("t2_stalled", 64'(stall_left), 64'd0);
        check("t2_count", 64'(n_win), 64'd6);
        check("t2_first", 64'(first_w), 64'h05040100);
        check("t2_last", 64'(last_w), 64'h0B0A0706);

        ready_mode = 0;
        gap_mode = 1;
        clear_stats();
        send_frame(8'h00, 12, 1'b1);
        drain();
        check("t3_count", 64'(n_win), 64'd6);
        check("t3_first", 64'(first_w), 64'h05040100);
        check("t3_eofs", 64'(n_eof), 64'd1);

        gap_mode = 0;
        send_frame(8'h80, 6, 1'b1);
        drain();
        clear_stats();
        send_frame(8'h40, 12, 1'b1);
        drain();
        check("t4_count", 64'(n_win), 64'd6);
        check("t4_first", 64'(first_w), 64'h45444140);
        check("t4_eofs", 64'(n_eof), 64'd1);

        ready_mode = 3;
        send_frame(8'h00, 6, 1'b1);
        check("t5_pending", 64'(win_valid), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t5_valid", 64'(win_valid), 64'd0);
        check("t5_data", 64'(win_data), 64'd0);
        check("t5_eol", 64'(win_eol), 64'd0);
        check("t5_eof", 64'(win_eof), 64'd0);
        ready_mode = 0;
        clear_stats();
        send_frame(8'h00, 12, 1'b0);
        drain();
        check("t5_count", 64'(n_win), 64'd6);
        check("t5_first", 64'(first_w), 64'h05040100);
        check("t5_last", 64'(last_w), 64'h0B0A0706);

        ready_mode = 1;
        gap_mode = 2;
        clear_stats();
        send_frame(8'h10, 12, 1'b1);
        send_frame(8'h20, 12, 1'b1);
        drain();
        check("t6_count", 64'(n_win), 64'd12);
        check("t6_eofs", 64'(n_eof), 64'd2);
        check("t6_first", 64'(first_w), 64'h15141110);
        check("t6_last", 64'(last_w), 64'h2B2A2726);

        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 12; i++) begin
                send_pix(DW'($urandom), (i == 0) || ($urandom_range(0, 15) == 0));
            end
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
